// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the parametrised RWS RAM.
package nv_ram_pkg;

    localparam int RAM_BYTE = 8;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    // Address width for a given depth; never narrower than one bit.
    function automatic int ram_depth_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/nv_ram_clr_ctl.sv
// Clear engine: walks every word once, zero-filling the array, after reset
// and on request. Owns the write port while busy.
module nv_ram_clr_ctl
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;

    // State and walk counter; reset lands in the walk so the array self-initialises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CLR_RUN;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state and outputs; requests during a walk do not restart it.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        clr_busy = 1'b0;
        clr_we   = 1'b0;
        case (state_q)
            CLR_RUN: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = CLR_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_RUN;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = CLR_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign clr_addr = addr_q;

endmodule

// File: rtl/nv_ram_rws_param.sv
// Parametrised 1R/1W RAM with byte-masked writes, optional output register,
// read-valid strobe and a zero-fill clear engine.
module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int AW      = ram_depth_aw(DEPTH),
    parameter int DW      = 128,
    parameter int NB      = DW / RAM_BYTE,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [NB-1:0] wmask,
    input  logic [DW-1:0] di,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int            AWP     = AW + 1;
    localparam logic [AW:0]   DEPTH_W = AWP'(DEPTH);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_ok;
    logic          rd_ok;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [NB-1:0] byte_we;
    logic [DW-1:0] rd_word;
    logic          rd_in_range;
    logic [AW-1:0] ra_q;
    logic          vld1_q;

    // Power-down bus is accepted for pin compatibility only.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    nv_ram_clr_ctl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_ctl (
        .clk      (clk),
        .rstn     (rstn),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // External traffic only while the clear engine is idle; out-of-range writes drop.
    assign wr_ok  = we && !clr_busy && ({1'b0, wa} < DEPTH_W);
    assign rd_ok  = re && !clr_busy;
    assign mem_wa = clr_we ? clr_addr : wa;
    assign mem_wd = clr_we ? '0 : di;

    // Out-of-range read addresses return zero rather than aliasing.
    assign rd_in_range = ({1'b0, ra_q} < DEPTH_W);

    // One byte lane per generate instance so masked writes never share a driver.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [RAM_BYTE-1:0] mem_q [DEPTH];

        assign byte_we[gi] = clr_we | (wr_ok & wmask[gi]);

        // Array lane write; contents are not reset, the clear engine covers them.
        always_ff @(posedge clk) begin
            if (byte_we[gi]) begin
                mem_q[mem_wa] <= mem_wd[gi*RAM_BYTE +: RAM_BYTE];
            end
        end

        assign rd_word[gi*RAM_BYTE +: RAM_BYTE] = rd_in_range ? mem_q[ra_q] : '0;
    end

    // Read address capture and stage-1 valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_q   <= '0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= rd_ok;
            if (rd_ok) begin
                ra_q <= ra;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DW-1:0] dout_q;
        logic          vld2_q;

        // Output register loads only on a new read and otherwise holds.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                dout_q <= '0;
                vld2_q <= 1'b0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    dout_q <= rd_word;
                end
            end
        end

        assign dout     = dout_q;
        assign dout_vld = vld2_q;
    end else begin : g_live
        // Live read of the captured address: later writes show through.
        assign dout     = rd_word;
        assign dout_vld = vld1_q;
    end

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Directed bench for nv_ram_rws_param: a 256x128 latency-1 instance and a
// 200x32 latency-2 instance, each with its own reference model and queue.
module tb_nv_ram_rws_param;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   compared;
    int   mismatched;

    // Instance A: DEPTH=256, DW=128, OUT_REG=0
    logic [7:0]   ra_a, wa_a;
    logic         re_a, we_a, vld_a, clr_req_a, busy_a;
    logic [127:0] dout_a, di_a;
    logic [15:0]  wmask_a;

    // Instance B: DEPTH=200, DW=32, OUT_REG=1
    logic [7:0]   ra_b, wa_b;
    logic         re_b, we_b, vld_b, clr_req_b, busy_b;
    logic [31:0]  dout_b, di_b;
    logic [3:0]   wmask_b;

    logic [127:0] model_a [256];
    logic [31:0]  model_b [200];
    exp_t         qa[$];
    exp_t         qb[$];

    nv_ram_rws_param #(.DEPTH(256), .DW(128), .OUT_REG(0)) u_dut_a (
        .clk(clk), .rstn(rstn), .ra(ra_a), .re(re_a), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa_a), .we(we_a), .wmask(wmask_a), .di(di_a), .clr_req(clr_req_a),
        .clr_busy(busy_a), .pwrbus_ram_pd(32'h0)
    );

    nv_ram_rws_param #(.DEPTH(200), .DW(32), .OUT_REG(1)) u_dut_b (
        .clk(clk), .rstn(rstn), .ra(ra_b), .re(re_b), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa_b), .we(we_b), .wmask(wmask_b), .di(di_b), .clr_req(clr_req_b),
        .clr_busy(busy_b), .pwrbus_ram_pd(32'hFFFF_FFFF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for A: data and exact strobe cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && vld_a) begin
            if (qa.size() == 0) begin
                check("a_spurious_vld", 128'd1, 128'd0);
            end else begin
                e = qa.pop_front();
                check("a_data", dout_a, e.data);
                check("a_latency", 128'(cyc), 128'(e.due));
            end
        end
    end

    // Scoreboard pop for B.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && vld_b) begin
            if (qb.size() == 0) begin
                check("b_spurious_vld", 128'd1, 128'd0);
            end else begin
                e = qb.pop_front();
                check("b_data", {96'd0, dout_b}, e.data);
                check("b_latency", 128'(cyc), 128'(e.due));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic zero_models();
        for (int i = 0; i < 256; i++) model_a[i] = '0;
        for (int i = 0; i < 200; i++) model_b[i] = '0;
    endtask

    task automatic op_a(input bit w, input logic [7:0] wa, input logic [127:0] d,
                        input logic [15:0] m, input bit r, input logic [7:0] ra);
        exp_t e;
        we_a = w; wa_a = wa; di_a = d; wmask_a = m; re_a = r; ra_a = ra;
        if (w) for (int i = 0; i < 16; i++) if (m[i]) model_a[wa][i*8 +: 8] = d[i*8 +: 8];
        if (r) begin
            e.data = model_a[ra];
            e.due  = cyc + 1;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        we_a = 1'b0; re_a = 1'b0;
    endtask

    task automatic op_b(input bit w, input logic [7:0] wa, input logic [31:0] d,
                        input logic [3:0] m, input bit r, input logic [7:0] ra);
        exp_t e;
        we_b = w; wa_b = wa; di_b = d; wmask_b = m; re_b = r; ra_b = ra;
        if (w && wa < 200) for (int i = 0; i < 4; i++) if (m[i]) model_b[wa][i*8 +: 8] = d[i*8 +: 8];
        if (r) begin
            e.data = (ra < 200) ? {96'd0, model_b[ra]} : 128'd0;
            e.due  = cyc + 2;
            qb.push_back(e);
        end
        @(posedge clk); #1;
        we_b = 1'b0; re_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Counts busy cycles of both instances, sampled on falling edges.
    task automatic count_busy(output int na, output int nb);
        na = 0; nb = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) break;
            if (busy_a) na++;
            if (busy_b) nb++;
        end
    endtask

    initial begin
        int na, nb;
        logic [7:0]   addrs [6];
        logic [127:0] d;

        cyc = 0; compared = 0; mismatched = 0;
        rstn = 1'b0;
        ra_a = '0; wa_a = '0; re_a = 0; we_a = 0; wmask_a = '0; di_a = '0; clr_req_a = 0;
        ra_b = '0; wa_b = '0; re_b = 0; we_b = 0; wmask_b = '0; di_b = '0; clr_req_b = 0;
        zero_models();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy_a", 128'(busy_a), 128'd1);
        check("rst_busy_b", 128'(busy_b), 128'd1);
        check("rst_vld_a", 128'(vld_a), 128'd0);
        check("rst_vld_b", 128'(vld_b), 128'd0);
        check("rst_dout_b", {96'd0, dout_b}, 128'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        count_busy(na, nb);
        check("auto_clear_cycles_a", 128'(na), 128'd256);
        check("auto_clear_cycles_b", 128'(nb), 128'd200);
        @(posedge clk); #1;

        // A: read of last address after clear, latency 1
        op_a(0, 8'h00, '0, '0, 1, 8'hFF);
        // A: masked write over an all-ones word
        op_a(1, 8'd5, {128{1'b1}}, 16'hFFFF, 0, 8'h00);
        op_a(1, 8'd5, 128'h000102030405060708090A0B0C0D0E0F, 16'h00FF, 0, 8'h00);
        check("mask_model", model_a[5], 128'hFFFFFFFFFFFFFFFF08090A0B0C0D0E0F);
        op_a(0, 8'h00, '0, '0, 1, 8'd5);
        // A: same-cycle write and read of address 7 is write-first
        op_a(1, 8'd7, {16{8'hA5}}, 16'hFFFF, 1, 8'd7);
        // A: random masked writes then back-to-back reads
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 8'($urandom_range(8, 255));
            d = {$urandom, $urandom, $urandom, $urandom};
            op_a(1, addrs[i], d, 16'($urandom), 0, 8'h00);
        end
        for (int i = 0; i < 6; i++) op_a(0, 8'h00, '0, '0, 1, addrs[i]);
        idle(3);

        // B: consecutive reads of 1,2,3, then dout must hold
        op_b(1, 8'd1, 32'h1111_0001, 4'hF, 0, 8'd0);
        op_b(1, 8'd2, 32'h2222_0002, 4'hF, 0, 8'd0);
        op_b(1, 8'd3, 32'h3333_0003, 4'hF, 0, 8'd0);
        op_b(0, 8'd0, '0, '0, 1, 8'd1);
        op_b(0, 8'd0, '0, '0, 1, 8'd2);
        op_b(0, 8'd0, '0, '0, 1, 8'd3);
        idle(4);
        @(negedge clk);
        check("b_dout_hold", {96'd0, dout_b}, {96'd0, model_b[3]});
        @(posedge clk); #1;

        // B: out-of-range write is dropped and out-of-range read returns zero
        op_b(1, 8'd10, 32'hCAFE_0010, 4'hF, 0, 8'd0);
        op_b(1, 8'd82, 32'hBEEF_0082, 4'b0101, 0, 8'd0);
        op_b(1, 8'd210, 32'hDEAD_D00D, 4'hF, 0, 8'd0);
        op_b(0, 8'd0, '0, '0, 1, 8'd210);
        op_b(0, 8'd0, '0, '0, 1, 8'd10);
        op_b(0, 8'd0, '0, '0, 1, 8'd82);
        idle(4);

        // B: clear request with a same-cycle write; traffic during busy ignored
        we_b = 1; wa_b = 8'd9; di_b = 32'h1234_5678; wmask_b = 4'hF; clr_req_b = 1;
        @(posedge clk); #1;
        we_b = 0; clr_req_b = 0;
        zero_models_b: for (int i = 0; i < 200; i++) model_b[i] = '0;
        nb = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy_b) break;
            nb++;
            if (nb >= 150) begin
                we_b = 1; wa_b = 8'd0; di_b = 32'hFFFF_FFFF; wmask_b = 4'hF;
                re_b = 1; ra_b = 8'd1;
            end
        end
        we_b = 0; re_b = 0;
        check("req_clear_cycles_b", 128'(nb), 128'd200);
        @(posedge clk); #1;
        op_b(0, 8'd0, '0, '0, 1, 8'd0);
        op_b(0, 8'd0, '0, '0, 1, 8'd9);
        op_b(0, 8'd0, '0, '0, 1, 8'd1);
        idle(4);

        // Reset in the middle of a clear restarts the walk from address 0
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(100);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_busy_a", 128'(busy_a), 128'd1);
        check("midrst_vld_b", 128'(vld_b), 128'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        zero_models();
        count_busy(na, nb);
        check("midrst_clear_cycles_a", 128'(na), 128'd256);
        check("midrst_clear_cycles_b", 128'(nb), 128'd200);
        @(posedge clk); #1;
        op_a(0, 8'h00, '0, '0, 1, 8'd5);
        op_a(0, 8'h00, '0, '0, 1, 8'd7);
        op_b(0, 8'd0, '0, '0, 1, 8'd3);
        idle(4);

        check("qa_drained", 128'(qa.size()), 128'd0);
        check("qb_drained", 128'(qb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
